// File: rtl/asg_multi_target_generator_if.sv
// asg_multi_target_generator_if: control, configuration and video bundle of the target generator
interface asg_multi_target_generator_if #(
   parameter int NUM_TGT = 8,
   parameter int POS_W   = 12,
   parameter int WID_W   = 4
);
   localparam int AW = NUM_TGT > 1 ? $clog2(NUM_TGT) : 1;
   logic             en;
   logic             mode;
   logic             trig;
   logic             usec;
   logic             cfg_we;
   logic [AW-1:0]    cfg_addr;
   logic [POS_W-1:0] cfg_pos;
   logic [WID_W-1:0] cfg_width;
   logic             gen_signal;
   logic             sweep_active;
   logic             sweep_done;
   modport master (
      output en, mode, trig, usec, cfg_we, cfg_addr, cfg_pos, cfg_width,
      input  gen_signal, sweep_active, sweep_done
   );
   modport slave (
      input  en, mode, trig, usec, cfg_we, cfg_addr, cfg_pos, cfg_width,
      output gen_signal, sweep_active, sweep_done
   );
endinterface

// File: rtl/asg_multi_target_generator.sv
// asg_multi_target_generator: NUM_TGT programmable fixed targets inside a USEC-stepped azimuth sweep,
// with a shadow table that only becomes active at sweep start
module asg_multi_target_generator #(
   parameter int SIZE    = 3200,
   parameter int NUM_TGT = 8,
   parameter int POS_W   = 12,
   parameter int WID_W   = 4
) (
   input logic                         sys_clk,
   input logic                         rst,
   asg_multi_target_generator_if.slave bus
);
   localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
   logic [0:0]       state;
   logic [POS_W-1:0] cnt;
   logic             trig_q, trig_rise, last, load, gen, done;
   logic [POS_W-1:0] sh_pos [NUM_TGT];
   logic [POS_W-1:0] act_pos [NUM_TGT];
   logic [WID_W-1:0] sh_wid [NUM_TGT];
   logic [WID_W-1:0] act_wid [NUM_TGT];
   logic [NUM_TGT-1:0] hit;
   assign trig_rise = bus.trig & ~trig_q;
   assign last      = cnt == POS_W'(SIZE - 1);
   // active table reloads on every sweep start: trigger or continuous wrap
   assign load      = bus.en & (trig_rise | ((state == RUN) & bus.usec & last & bus.mode));
   assign bus.gen_signal   = gen;
   assign bus.sweep_done   = done;
   assign bus.sweep_active = state == RUN;
   // end compared one bit wider so pos+width never wraps
   for (genvar i = 0; i < NUM_TGT; i++) begin : g_hit
      assign hit[i] = (act_wid[i] != '0) && (cnt >= act_pos[i]) &&
                      ({1'b0, cnt} < ({1'b0, act_pos[i]} + (POS_W + 1)'(act_wid[i])));
   end
   always_ff @(posedge sys_clk or posedge rst)
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         trig_q <= 1'b0;
         gen    <= 1'b0;
         done   <= 1'b0;
      end else begin
         trig_q <= bus.trig;
         done   <= 1'b0;
         gen    <= bus.en & (state == RUN) & (|hit);
         if (!bus.en) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (trig_rise) begin
            state <= RUN;
            cnt   <= '0;
         end else if (state == RUN && bus.usec) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
               done  <= 1'b1;
               state <= bus.mode ? RUN : IDLE;
            end
         end
      end
   always_ff @(posedge sys_clk or posedge rst)
      if (rst) begin
         for (int k = 0; k < NUM_TGT; k++) begin
            sh_pos[k]  <= '0;
            sh_wid[k]  <= '0;
            act_pos[k] <= '0;
            act_wid[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_TGT; k++)
            if (load) begin
               act_pos[k] <= sh_pos[k];
               act_wid[k] <= sh_wid[k];
            end
         if (bus.cfg_we && int'(bus.cfg_addr) < NUM_TGT) begin
            sh_pos[bus.cfg_addr] <= bus.cfg_pos;
            sh_wid[bus.cfg_addr] <= bus.cfg_width;
         end
      end
endmodule
